// File: rtl/fp32_pkg.sv
// Shared single-precision constants, field helpers and the arbiter state type.
package fp32_pkg;

    localparam int FP32_W = 32;
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;

    localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FC0_0000;
    localparam logic [FP32_W-1:0] FP32_PINF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [EXP_W-1:0] fp32_exp(input logic [FP32_W-1:0] x);
        return x[FP32_W-2 -: EXP_W];
    endfunction

    function automatic logic [MAN_W-1:0] fp32_man(input logic [FP32_W-1:0] x);
        return x[MAN_W-1:0];
    endfunction

endpackage

// File: rtl/fp32_mul.sv
// Combinational IEEE-754 single-precision multiplier, round-to-nearest-even.
// Denormal inputs are treated as zero and underflowing results flush to signed zero;
// any NaN operand, or Inf times zero, yields the canonical quiet NaN.
module fp32_mul
    import fp32_pkg::*;
(
    input  logic [FP32_W-1:0] a,
    input  logic [FP32_W-1:0] b,
    output logic [FP32_W-1:0] y
);

    logic             sign;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0]      prod;
    logic [MAN_W-1:0] mant;
    logic [MAN_W:0]   mant_rnd;
    logic             guard, sticky, round_up;
    logic [9:0]       exp_sum;

    assign sign   = a[FP32_W-1] ^ b[FP32_W-1];
    assign a_nan  = (fp32_exp(a) == '1) && (fp32_man(a) != '0);
    assign b_nan  = (fp32_exp(b) == '1) && (fp32_man(b) != '0);
    assign a_inf  = (fp32_exp(a) == '1) && (fp32_man(a) == '0);
    assign b_inf  = (fp32_exp(b) == '1) && (fp32_man(b) == '0);
    assign a_zero = (fp32_exp(a) == '0);
    assign b_zero = (fp32_exp(b) == '0);

    // Special-case selection, then normalise / round / range-check the finite product.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        y        = '0;
        prod     = {1'b1, fp32_man(a)} * {1'b1, fp32_man(b)};
        mant     = '0;
        guard    = 1'b0;
        sticky   = 1'b0;
        round_up = 1'b0;
        mant_rnd = '0;
        exp_sum  = 10'(fp32_exp(a)) + 10'(fp32_exp(b)) + 10'(prod[47]);

        if (prod[47]) begin
            mant   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
        end else begin
            mant   = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end
        round_up = guard && (sticky || mant[0]);
        mant_rnd = {1'b0, mant} + 24'(round_up);
        // A carry out of the rounded mantissa leaves its fraction bits all zero.
        exp_sum  = exp_sum + 10'(mant_rnd[MAN_W]);

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            y = FP32_QNAN;
        end else if (a_inf || b_inf) begin
            y = FP32_PINF | {sign, 31'd0};
        end else if (a_zero || b_zero) begin
            y = {sign, 31'd0};
        end else if (exp_sum >= 10'd382) begin
            y = FP32_PINF | {sign, 31'd0};
        end else if (exp_sum <= 10'd127) begin
            y = {sign, 31'd0};
        end else begin
            y = {sign, 8'(exp_sum - 10'd127), mant_rnd[MAN_W-1:0]};
        end
    end

endmodule

// File: rtl/fp_rr_pick.sv
// Combinational round-robin picker: first asserted request scanning from ptr upward, wrapping.
module fp_rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   idx,
    output logic             any
);

    // Scan farthest-first so the candidate nearest to ptr overwrites the rest.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int j;
            j = (int'(ptr) + k) % N_REQ;
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = IDW'(j);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one combinational fp32 multiplier among N_REQ round-robin requesters,
// one operation in flight, result held on a valid/ready channel.
module fp_mul_arbiter
    import fp32_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDW   = 2,
    parameter int CNTW  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [FP32_W*N_REQ-1:0] req_a,
    input  logic [FP32_W*N_REQ-1:0] req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [FP32_W-1:0]       rsp_data,
    output logic [IDW-1:0]          rsp_id,
    output logic                    busy,
    output logic [CNTW-1:0]         ops_done
);

    state_t             state, state_nx;
    logic [IDW-1:0]     rr_ptr;
    logic [FP32_W-1:0]  op_a, op_b, mul_out;
    logic [IDW-1:0]     op_id;
    logic [N_REQ-1:0]   gnt;
    logic [IDW-1:0]     win_idx;
    logic               win_any;
    logic               accept_win, accept;

    fp_rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (win_idx),
        .any (win_any)
    );

    fp32_mul u_mul (
        .a (op_a),
        .b (op_b),
        .y (mul_out)
    );

    // A new operation may start when idle or when the held result leaves this cycle.
    assign accept_win = (state == IDLE) || ((state == RESP) && rsp_ready);
    assign req_ready  = (accept_win && rst_n) ? gnt : '0;
    assign accept     = accept_win && win_any;
    assign busy       = (state != IDLE);

    // Next-state logic for IDLE -> EXEC -> RESP, with RESP able to chain straight into EXEC.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = accept ? EXEC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, operand capture, result register and completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            ops_done  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_a   <= req_a[FP32_W*int'(win_idx) +: FP32_W];
                op_b   <= req_b[FP32_W*int'(win_idx) +: FP32_W];
                op_id  <= win_idx;
                rr_ptr <= (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
            end
            if (state == EXEC) begin
                rsp_data  <= mul_out;
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
                ops_done  <= ops_done + 1'b1;
            end
        end
    end

endmodule
